// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the burst arbiter and its LFSR datapath:
//   - arb_state_e   : arbiter FSM encoding (IDLE / RUN / GAP)
//   - LFSR_W        : LFSR width (4 bits)
//   - LFSR_LOCKUP   : the one state an XNOR Fibonacci LFSR never leaves
//   - LFSR_RESET    : value the LFSR takes on reset
//   - lfsr4_next()  : one step of the 4-bit XNOR Fibonacci LFSR
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 4;

    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 4'b1111;
    localparam logic [LFSR_W-1:0] LFSR_RESET  = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Taps at bits 3 and 2 with XNOR feedback give a 15-state cycle that
    // includes 0000 and excludes 1111.
    function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] q);
        return {q[2:0], ~(q[3] ^ q[2])};
    endfunction

endpackage

// File: rtl/lfsr4_core.sv
// -----------------------------------------------------------------------------
// lfsr4_core
// Holds the 4-bit LFSR register. Load has priority over step. The caller is
// responsible for never loading the lockup value.
// Ports:
//   clk       in  1  clock, rising edge
//   reset     in  1  synchronous active-high reset (register -> LFSR_RESET)
//   load      in  1  load load_val on the next edge
//   load_val  in  4  value to load
//   step      in  1  advance the LFSR one position on the next edge
//   q         out 4  current LFSR state
// -----------------------------------------------------------------------------
module lfsr4_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= LFSR_RESET;
        end else if (load) begin
            q_reg <= load_val;
        end else if (step) begin
            q_reg <= lfsr4_next(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/lfsr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_burst_arbiter
// Shares one 4-bit LFSR among N_REQ requesters. Requests are granted
// round-robin; each grant delivers a burst of pseudo-random nibbles, one per
// cycle, stepping the LFSR once per beat. Also handles seeding of the LFSR.
// Ports:
//   clk        in  1            clock, rising edge
//   reset      in  1            synchronous active-high reset
//   seed_we    in  1            load seed_in (only acted on while idle)
//   seed_in    in  4            seed value (1111 is loaded as 0000)
//   req        in  N_REQ        level burst request per requester
//   req_len    in  N_REQ*LEN_W  burst length per requester, 0 = 2**LEN_W
//   gnt        out N_REQ        one-hot grant, held for the burst
//   rnd_valid  out 1            rnd_data valid this cycle
//   rnd_data   out 4            random nibble
//   rnd_last   out 1            final beat of the burst
//   busy       out 1            arbiter not idle
//   lfsr_q     out 4            current LFSR state
// -----------------------------------------------------------------------------
module lfsr_burst_arbiter
    import lfsr_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int LEN_W = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seed_we,
    input  logic [LFSR_W-1:0]      seed_in,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rnd_valid,
    output logic [LFSR_W-1:0]      rnd_data,
    output logic                   rnd_last,
    output logic                   busy,
    output logic [LFSR_W-1:0]      lfsr_q
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = LEN_W + 1;

    localparam logic [OW:0]   NREQ_C   = (OW+1)'(N_REQ);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
    localparam logic [CW-1:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

    // ---------------------------------------------------------------- state
    arb_state_e         state_reg,     state_next;
    logic [OW-1:0]      owner_reg,     owner_next;
    logic [OW-1:0]      rr_ptr_reg,    rr_ptr_next;
    logic [CW-1:0]      count_reg,     count_next;
    logic [N_REQ-1:0]   gnt_reg,       gnt_next;
    logic               rnd_valid_reg, rnd_valid_next;
    logic [LFSR_W-1:0]  rnd_data_reg,  rnd_data_next;
    logic               rnd_last_reg,  rnd_last_next;
    logic               busy_reg,      busy_next;

    logic               lfsr_load;
    logic [LFSR_W-1:0]  lfsr_load_val;
    logic               lfsr_step;

    // ------------------------------------------------------- request slicing
    logic [LEN_W-1:0] len_arr  [N_REQ];
    logic [OW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;

    // cand_idx[gi] is the requester gi places after rr_ptr (wrapping), so
    // the lowest set cand_req bit is the round-robin winner.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [OW:0] cand_sum;

            assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
            assign cand_sum     = {1'b0, rr_ptr_reg} + (OW+1)'(gi);
            assign cand_idx[gi] = (cand_sum >= NREQ_C) ? OW'(cand_sum - NREQ_C)
                                                       : cand_sum[OW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic [LEN_W-1:0]  pick_len;
    logic [CW-1:0]     pick_len_eff;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        // Scan downward so the nearest candidate is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    assign pick_len     = len_arr[pick_idx];
    assign pick_len_eff = (pick_len == '0) ? FULL_LEN : {1'b0, pick_len};

    // ------------------------------------------------------------- LFSR core
    lfsr4_core u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    // ------------------------------------------------------- next-state logic
    // Outputs are registered, so the first beat is produced on the same edge
    // that grants: beat 1 is visible in the first RUN cycle. count_reg holds
    // the number of beats still to be produced after the one on display.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        count_next     = count_reg;
        gnt_next       = gnt_reg;
        rnd_valid_next = 1'b0;
        rnd_data_next  = rnd_data_reg;
        rnd_last_next  = 1'b0;
        lfsr_load      = 1'b0;
        lfsr_load_val  = seed_in;
        lfsr_step      = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                gnt_next = '0;
                if (seed_we) begin
                    // Seeding takes the cycle; any request waits one cycle.
                    lfsr_load     = 1'b1;
                    lfsr_load_val = (seed_in == LFSR_LOCKUP) ? LFSR_RESET : seed_in;
                end else if (pick_found) begin
                    state_next     = ST_RUN;
                    owner_next     = pick_idx;
                    gnt_next       = N_REQ'(1) << pick_idx;
                    rnd_valid_next = 1'b1;
                    rnd_data_next  = lfsr_q;
                    rnd_last_next  = (pick_len_eff == CW'(1));
                    lfsr_step      = 1'b1;
                    count_next     = pick_len_eff - CW'(1);
                end
            end

            ST_RUN: begin
                if (count_reg == '0) begin
                    // Last beat is on display: close the burst.
                    state_next = ST_GAP;
                    gnt_next   = '0;
                end else if (!req[owner_reg]) begin
                    // Owner withdrew: abandon without a final beat.
                    state_next = ST_GAP;
                    gnt_next   = '0;
                    count_next = '0;
                end else begin
                    rnd_valid_next = 1'b1;
                    rnd_data_next  = lfsr_q;
                    rnd_last_next  = (count_reg == CW'(1));
                    lfsr_step      = 1'b1;
                    count_next     = count_reg - CW'(1);
                end
            end

            ST_GAP: begin
                gnt_next    = '0;
                rr_ptr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + OW'(1);
                state_next  = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            count_reg     <= '0;
            gnt_reg       <= '0;
            rnd_valid_reg <= 1'b0;
            rnd_data_reg  <= '0;
            rnd_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            count_reg     <= count_next;
            gnt_reg       <= gnt_next;
            rnd_valid_reg <= rnd_valid_next;
            rnd_data_reg  <= rnd_data_next;
            rnd_last_reg  <= rnd_last_next;
            busy_reg      <= busy_next;
        end
    end

    assign gnt       = gnt_reg;
    assign rnd_valid = rnd_valid_reg;
    assign rnd_data  = rnd_data_reg;
    assign rnd_last  = rnd_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lfsr_burst_arbiter
// Directed bench for lfsr_burst_arbiter (N_REQ=2, LEN_W=4). Inputs change
// just after the falling edge; outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_lfsr_burst_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       seed_we;
    logic [3:0] seed_in;
    logic [1:0] req;
    logic [7:0] req_len;
    logic [1:0] gnt;
    logic       rnd_valid;
    logic [3:0] rnd_data;
    logic       rnd_last;
    logic       busy;
    logic [3:0] lfsr_q;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lfsr_burst_arbiter #(.N_REQ(2), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_we   (seed_we),
        .seed_in   (seed_in),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_last  (rnd_last),
        .busy      (busy),
        .lfsr_q    (lfsr_q)
    );

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        seed_we = 1'b0;
        seed_in = 4'h0;
        req     = 2'b00;
        req_len = 8'h00;
        step_cycle();
        step_cycle();
        reset = 1'b0;
    endtask

    // 1: idle after reset
    task automatic test_reset();
        logic [8:0] obs;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            obs = {lfsr_q, gnt, rnd_valid, rnd_last, busy};
            total_cnt++;
            if (obs !== 9'h000) $display("FAIL reset_idle cyc%0d: got %h expected 000", c, obs);
            else pass_cnt++;
            step_cycle();
        end
        $display("reset: idle 10 cycles checked");
    endtask

    // 2: seed 0000, 4-beat burst on requester 0, req_len change after grant ignored
    task automatic test_basic_burst();
        logic [15:0] exp_data;
        logic [3:0]  d;
        exp_data = 16'h0137;
        do_reset();
        seed_we = 1'b1; seed_in = 4'h0;
        step_cycle();
        seed_we = 1'b0; req = 2'b01; req_len = 8'h04;
        step_cycle();
        req_len = 8'h01;
        for (int b = 0; b < 4; b++) begin
            d = exp_data[15-4*b -: 4];
            $display("basic beat %0d: gnt=%b valid=%b data=%h last=%b", b+1, gnt, rnd_valid, rnd_data, rnd_last);
            total_cnt++;
            if ({gnt, rnd_valid, rnd_last, busy, rnd_data} !== {2'b01, 1'b1, (b == 3), 1'b1, d})
                $display("FAIL basic_beat%0d: got gnt=%b v=%b l=%b busy=%b d=%h expected gnt=01 v=1 l=%0d busy=1 d=%h",
                         b+1, gnt, rnd_valid, rnd_last, busy, rnd_data, (b == 3), d);
            else pass_cnt++;
            if (b == 3) req = 2'b00;
            step_cycle();
        end
        total_cnt++;
        if ({gnt, rnd_valid, rnd_last, busy, lfsr_q} !== {2'b00, 1'b0, 1'b0, 1'b1, 4'b1110})
            $display("FAIL basic_gap: got gnt=%b v=%b l=%b busy=%b q=%b expected 00 0 0 1 1110",
                     gnt, rnd_valid, rnd_last, busy, lfsr_q);
        else pass_cnt++;
        step_cycle();
        total_cnt++;
        if ({busy, lfsr_q} !== {1'b0, 4'b1110})
            $display("FAIL basic_idle: got busy=%b q=%b expected 0 1110", busy, lfsr_q);
        else pass_cnt++;
    endtask

    // 3: both requesters held, len 2 each -> strict alternation
    task automatic test_back_to_back();
        // {gnt[1:0], valid, last, busy, data[3:0]} per cycle
        logic [8:0] exp_tab [0:9];
        logic [8:0] obs;
        exp_tab = '{9'b01_1_0_1_0000, 9'b01_1_1_1_0001, 9'b00_0_0_1_0000, 9'b00_0_0_0_0000,
                    9'b10_1_0_1_0011, 9'b10_1_1_1_0111, 9'b00_0_0_1_0000, 9'b00_0_0_0_0000,
                    9'b01_1_0_1_1110, 9'b01_1_1_1_1101};
        do_reset();
        req = 2'b11; req_len = 8'h22;
        step_cycle();
        for (int c = 0; c < 10; c++) begin
            obs = {gnt, rnd_valid, rnd_last, busy, (rnd_valid ? rnd_data : 4'h0)};
            $display("b2b cyc %0d: gnt=%b valid=%b data=%h last=%b busy=%b", c+1, gnt, rnd_valid, rnd_data, rnd_last, busy);
            total_cnt++;
            if (obs !== exp_tab[c]) $display("FAIL b2b_cyc%0d: got %b expected %b", c+1, obs, exp_tab[c]);
            else pass_cnt++;
            step_cycle();
        end
        req = 2'b00;
    endtask

    // 4: seeding, lockup substitution, seed-vs-req priority, seed ignored in RUN
    task automatic test_seed();
        logic [15:0] exp_data;
        logic [3:0]  d;
        exp_data = 16'h5A48;
        do_reset();
        seed_we = 1'b1; seed_in = 4'b0101;
        step_cycle();
        total_cnt++;
        if (lfsr_q !== 4'b0101) $display("FAIL seed_load: got %b expected 0101", lfsr_q);
        else pass_cnt++;
        seed_in = 4'b1111;
        step_cycle();
        total_cnt++;
        if (lfsr_q !== 4'b0000) $display("FAIL seed_lockup: got %b expected 0000", lfsr_q);
        else pass_cnt++;
        seed_in = 4'b0101; req = 2'b01; req_len = 8'h04;
        step_cycle();
        total_cnt++;
        if ({gnt, busy, lfsr_q} !== {2'b00, 1'b0, 4'b0101})
            $display("FAIL seed_wins: got gnt=%b busy=%b q=%b expected 00 0 0101", gnt, busy, lfsr_q);
        else pass_cnt++;
        seed_we = 1'b0;
        step_cycle();
        for (int b = 0; b < 4; b++) begin
            d = exp_data[15-4*b -: 4];
            $display("seed beat %0d: gnt=%b valid=%b data=%h last=%b", b+1, gnt, rnd_valid, rnd_data, rnd_last);
            total_cnt++;
            if ({gnt, rnd_valid, rnd_data} !== {2'b01, 1'b1, d})
                $display("FAIL seed_run_beat%0d: got gnt=%b v=%b d=%h expected 01 1 %h", b+1, gnt, rnd_valid, rnd_data, d);
            else pass_cnt++;
            if (b == 0) begin seed_we = 1'b1; seed_in = 4'b0101; end
            if (b == 3) begin seed_we = 1'b0; req = 2'b00; end
            step_cycle();
        end
        total_cnt++;
        if (lfsr_q !== 4'b0000) $display("FAIL seed_after_run: got %b expected 0000", lfsr_q);
        else pass_cnt++;
    endtask

    // 5: len=0 -> 16 beats, wraps after 15
    task automatic test_len_zero();
        logic [63:0] seq;
        logic [3:0]  d;
        logic [3:0]  first;
        seq = 64'h0137EDB6C925A480;
        first = 4'h0;
        do_reset();
        req = 2'b01; req_len = 8'h00;
        step_cycle();
        for (int b = 0; b < 16; b++) begin
            d = seq[63-4*b -: 4];
            if (b == 0) first = rnd_data;
            $display("len0 beat %0d: valid=%b data=%h last=%b", b+1, rnd_valid, rnd_data, rnd_last);
            total_cnt++;
            if ({rnd_valid, rnd_last, rnd_data} !== {1'b1, (b == 15), d})
                $display("FAIL len0_beat%0d: got v=%b l=%b d=%h expected 1 %0d %h", b+1, rnd_valid, rnd_last, rnd_data, (b == 15), d);
            else pass_cnt++;
            if (b == 15) begin
                total_cnt++;
                if (rnd_data !== first) $display("FAIL len0_wrap: got %h expected %h", rnd_data, first);
                else pass_cnt++;
                req = 2'b00;
            end
            step_cycle();
        end
        total_cnt++;
        if ({gnt, rnd_valid, busy} !== 4'b0001)
            $display("FAIL len0_gap: got gnt=%b v=%b busy=%b expected 00 0 1", gnt, rnd_valid, busy);
        else pass_cnt++;
    endtask

    // 6: abort by dropping req, round-robin advance, reset mid-burst
    task automatic test_abort_reset();
        do_reset();
        req = 2'b01; req_len = 8'h08;
        step_cycle();
        total_cnt++;
        if ({gnt, rnd_valid, rnd_last, rnd_data} !== {2'b01, 1'b1, 1'b0, 4'h0})
            $display("FAIL abort_beat1: got gnt=%b v=%b l=%b d=%h expected 01 1 0 0", gnt, rnd_valid, rnd_last, rnd_data);
        else pass_cnt++;
        req = 2'b00;
        step_cycle();
        $display("abort: gnt=%b valid=%b last=%b busy=%b q=%b", gnt, rnd_valid, rnd_last, busy, lfsr_q);
        total_cnt++;
        if ({gnt, rnd_valid, rnd_last, busy, lfsr_q} !== {2'b00, 1'b0, 1'b0, 1'b1, 4'b0001})
            $display("FAIL abort_gap: got gnt=%b v=%b l=%b busy=%b q=%b expected 00 0 0 1 0001",
                     gnt, rnd_valid, rnd_last, busy, lfsr_q);
        else pass_cnt++;
        step_cycle();
        total_cnt++;
        if ({busy, rnd_valid, rnd_last} !== 3'b000)
            $display("FAIL abort_idle: got busy=%b v=%b l=%b expected 0 0 0", busy, rnd_valid, rnd_last);
        else pass_cnt++;
        req = 2'b11; req_len = 8'h88;
        step_cycle();
        total_cnt++;
        if ({gnt, rnd_valid, rnd_data} !== {2'b10, 1'b1, 4'b0001})
            $display("FAIL abort_rr_next: got gnt=%b v=%b d=%h expected 10 1 1", gnt, rnd_valid, rnd_data);
        else pass_cnt++;
        step_cycle();
        total_cnt++;
        if ({gnt, rnd_valid, rnd_data} !== {2'b10, 1'b1, 4'b0011})
            $display("FAIL midburst_beat2: got gnt=%b v=%b d=%h expected 10 1 3", gnt, rnd_valid, rnd_data);
        else pass_cnt++;
        reset = 1'b1;
        step_cycle();
        $display("reset mid-burst: gnt=%b valid=%b data=%h last=%b busy=%b q=%b", gnt, rnd_valid, rnd_data, rnd_last, busy, lfsr_q);
        total_cnt++;
        if ({gnt, rnd_valid, rnd_data, rnd_last, busy, lfsr_q} !== 13'h0)
            $display("FAIL midburst_reset: got gnt=%b v=%b d=%h l=%b busy=%b q=%b expected all zero",
                     gnt, rnd_valid, rnd_data, rnd_last, busy, lfsr_q);
        else pass_cnt++;
        reset = 1'b0;
        req = 2'b00;
    endtask

    initial begin
        reset   = 1'b1;
        seed_we = 1'b0;
        seed_in = 4'h0;
        req     = 2'b00;
        req_len = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic_burst();
        test_back_to_back();
        test_seed();
        test_len_zero();
        test_abort_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
